// File: rtl/ne_pkg.sv
// Shared definitions for the NE feature stream: default widths and FSM encoding.
package ne_pkg;

  localparam int NE_FEAT_WIDTH = 40;
  localparam int NE_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ALARM = 2'd2,
    ST_HOLD  = 2'd3
  } ne_state_t;

endpackage

// File: rtl/ne_sat_counter.sv
// Counter with load, saturating increment and decrement-to-zero; load wins over inc, inc over dec.
module ne_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  // Count register; sticks at all-ones on inc and at zero on dec.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (inc) begin
      if (cnt != '1) cnt <= cnt + W'(1);
    end else if (dec) begin
      if (cnt != '0) cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/ne_event_detector.sv
// NE event detector: hysteresis threshold with N-window confirmation, refractory
// holdoff, event counting and peak capture during the alarm.
module ne_event_detector
  import ne_pkg::*;
#(
  parameter int FEAT_WIDTH = NE_FEAT_WIDTH,
  parameter int CNT_WIDTH  = NE_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [FEAT_WIDTH-1:0] din,
  input  logic                         din_valid,
  input  logic signed [FEAT_WIDTH-1:0] thr_hi,
  input  logic signed [FEAT_WIDTH-1:0] thr_lo,
  input  logic        [CNT_WIDTH-1:0]  n_confirm,
  input  logic        [CNT_WIDTH-1:0]  n_holdoff,
  output logic                         detect,
  output logic                         detect_pulse,
  output logic        [CNT_WIDTH-1:0]  event_count,
  output logic signed [FEAT_WIDTH-1:0] peak,
  output logic        [1:0]            state
);

  ne_state_t state_q, state_nxt;

  logic                 accept, above, below, enter_alarm;
  logic [CNT_WIDTH-1:0] confirm, holdoff;
  logic                 conf_load, conf_inc;
  logic [CNT_WIDTH-1:0] conf_val;
  logic                 hold_load, hold_dec;
  logic                 conf_reached;

  assign accept = din_valid & ~en;
  assign above  = din > thr_hi;
  assign below  = din < thr_lo;
  // Widened by one bit so a saturated confirm count still compares correctly.
  assign conf_reached = ({1'b0, confirm} + (CNT_WIDTH+1)'(1)) >= {1'b0, n_confirm};
  assign state = state_q;

  // Next-state and counter control decode for one accepted sample.
  always_comb begin
    state_nxt   = state_q;
    enter_alarm = 1'b0;
    conf_load   = 1'b0;
    conf_val    = '0;
    conf_inc    = 1'b0;
    hold_load   = 1'b0;
    hold_dec    = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (above) begin
            conf_load = 1'b1;
            conf_val  = CNT_WIDTH'(1);
            if (n_confirm <= CNT_WIDTH'(1)) enter_alarm = 1'b1;
            else                            state_nxt   = ST_PEND;
          end
        end
        ST_PEND: begin
          if (above) begin
            conf_inc = 1'b1;
            if (conf_reached) enter_alarm = 1'b1;
          end else begin
            conf_load = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_ALARM: begin
          if (below) begin
            conf_load = 1'b1;
            if (n_holdoff == '0) state_nxt = ST_IDLE;
            else begin
              hold_load = 1'b1;
              state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Thresholds are ignored here, including on the sample that ends the holdoff.
          hold_dec = 1'b1;
          if (holdoff <= CNT_WIDTH'(1)) begin
            conf_load = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      if (enter_alarm) state_nxt = ST_ALARM;
    end
  end

  ne_sat_counter #(.W(CNT_WIDTH)) u_confirm (
    .clk(clk), .rst(rst), .load(conf_load), .load_val(conf_val),
    .inc(conf_inc), .dec(1'b0), .cnt(confirm)
  );

  ne_sat_counter #(.W(CNT_WIDTH)) u_holdoff (
    .clk(clk), .rst(rst), .load(hold_load), .load_val(n_holdoff),
    .inc(1'b0), .dec(hold_dec), .cnt(holdoff)
  );

  ne_sat_counter #(.W(CNT_WIDTH)) u_events (
    .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
    .inc(enter_alarm), .dec(1'b0), .cnt(event_count)
  );

  // State, detect flags and peak tracking; peak is held outside ALARM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      detect       <= 1'b0;
      detect_pulse <= 1'b0;
      peak         <= '0;
    end else begin
      state_q      <= state_nxt;
      detect       <= (state_nxt == ST_ALARM);
      detect_pulse <= enter_alarm;
      if (enter_alarm)
        peak <= din;
      else if (accept && state_q == ST_ALARM && din > peak)
        peak <= din;
    end
  end

endmodule

// File: tb/tb_ne_event_detector.sv
// Directed bench for ne_event_detector: confirmation, broken runs, holdoff,
// gating, edge configurations, async reset and event-count saturation.
module tb_ne_event_detector;

  logic clk = 1'b0;
  logic rst, en, din_valid;
  logic signed [39:0] din, thr_hi, thr_lo;
  logic [7:0] n_confirm, n_holdoff;
  logic detect, detect_pulse;
  logic [7:0] event_count;
  logic signed [39:0] peak;
  logic [1:0] state;

  // Narrow-counter instance for the saturation check.
  logic [1:0] n_confirm_s, n_holdoff_s;
  logic detect_s, detect_pulse_s;
  logic [1:0] event_count_s;
  logic signed [39:0] peak_s;
  logic [1:0] state_s;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ne_event_detector #(.FEAT_WIDTH(40), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .n_confirm(n_confirm), .n_holdoff(n_holdoff),
    .detect(detect), .detect_pulse(detect_pulse), .event_count(event_count),
    .peak(peak), .state(state)
  );

  ne_event_detector #(.FEAT_WIDTH(40), .CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .n_confirm(n_confirm_s), .n_holdoff(n_holdoff_s),
    .detect(detect_s), .detect_pulse(detect_pulse_s), .event_count(event_count_s),
    .peak(peak_s), .state(state_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accepted sample; outputs are checked 1 time unit after the accepting edge.
  task automatic acc(input logic signed [39:0] v);
    @(negedge clk);
    din = v;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; din_valid = 1'b0; din = '0;
    thr_hi = 40'sd1000; thr_lo = 40'sd500; n_confirm = 8'd3; n_holdoff = 8'd2;
    n_confirm_s = 2'd1; n_holdoff_s = 2'd0;
    #1;
    chk("rst_detect", detect, 0);
    chk("rst_pulse", detect_pulse, 0);
    chk("rst_count", event_count, 0);
    chk("rst_peak", peak, 0);
    chk("rst_state", state, 0);
    idle(2);
    @(negedge clk) rst = 1'b1;

    // Confirmation
    acc(1200); chk("conf1_state", state, 1);
    acc(1300); chk("conf2_state", state, 1); chk("conf2_detect", detect, 0);
    acc(1400);
    chk("conf3_detect", detect, 1); chk("conf3_pulse", detect_pulse, 1);
    chk("conf3_count", event_count, 1); chk("conf3_peak", peak, 1400);
    chk("conf3_state", state, 2);
    idle(1); chk("pulse_width", detect_pulse, 0); chk("detect_hold", detect, 1);

    // Release and refractory
    acc(1600); chk("rel_peak_up", peak, 1600); chk("rel_state_alarm", state, 2);
    acc(400); chk("rel_detect", detect, 0); chk("rel_state_hold", state, 3);
    chk("rel_peak_kept", peak, 1600);
    acc(2000); chk("hold1_state", state, 3); chk("hold1_detect", detect, 0);
    acc(2000); chk("hold2_state", state, 0); chk("hold2_detect", detect, 0);
    acc(1200); acc(1200); acc(1200);
    chk("alarm2_count", event_count, 2); chk("alarm2_peak", peak, 1200);
    chk("alarm2_pulse", detect_pulse, 1);
    acc(1100); chk("peak_no_drop", peak, 1200);
    acc(400); acc(0); acc(0); chk("alarm2_idle", state, 0);

    // Broken run
    acc(1200); acc(1300); acc(900);
    chk("broken_idle", state, 0); chk("broken_detect", detect, 0);
    acc(1500); chk("broken_pend", state, 1); chk("broken_count", event_count, 2);

    // Gating with en high
    acc(1300); chk("gate_pend", state, 1);
    @(negedge clk); en = 1'b1; din_valid = 1'b1; din = 1500;
    idle(10);
    chk("gate_en_state", state, 1); chk("gate_en_detect", detect, 0);
    chk("gate_en_count", event_count, 2);
    @(negedge clk); en = 1'b0; din_valid = 1'b0;
    idle(3); chk("gate_nv_state", state, 1);
    acc(1500); chk("gate_alarm", state, 2); chk("gate_count", event_count, 3);
    acc(400); acc(0); acc(0); chk("gate_idle", state, 0);

    // n_confirm=0, n_holdoff=0
    n_confirm = 8'd0; n_holdoff = 8'd0;
    acc(1200); chk("nc0_state", state, 2); chk("nc0_count", event_count, 4);
    acc(400); chk("nh0_state", state, 0); chk("nh0_detect", detect, 0);
    n_confirm = 8'd3; n_holdoff = 8'd2;

    // din_valid low between samples
    acc(1200); idle(3); acc(1300); idle(3); chk("gap_pend", state, 1);
    acc(1500); chk("gap_alarm", state, 2); chk("gap_count", event_count, 5);

    // Async reset mid-cycle while in ALARM
    #2 rst = 1'b0;
    #1;
    chk("arst_detect", detect, 0); chk("arst_count", event_count, 0);
    chk("arst_peak", peak, 0); chk("arst_state", state, 0);
    @(negedge clk) rst = 1'b1;
    acc(1200); acc(1200); acc(1200);
    chk("post_rst_count", event_count, 1); chk("post_rst_detect", detect, 1);

    // Saturation of a 2-bit event counter over 5 alarms
    #2 rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    n_confirm = 8'd1; n_holdoff = 8'd0;
    for (int i = 0; i < 5; i++) begin
      acc(1200);
      acc(400);
    end
    chk("sat_count_narrow", event_count_s, 3);
    chk("sat_count_wide", event_count, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ne_event_detector.md
Name: ne_event_detector

Overview:
- Consumer end of the NE feature stream. Takes the windowed NE value and its data_valid strobe from the NE datapath.
- Applies a hysteresis threshold with an N-consecutive-window confirmation and a refractory holdoff.
- Emits a registered detection flag, a one-cycle event pulse, a saturating event count and the peak feature value seen during the alarm.
- Sits between the NE datapath and the system controller.

Parameters:
- FEAT_WIDTH, 40, width of the signed NE feature input (matches the NE datapath output width).
- CNT_WIDTH, 8, width of the confirm counter, holdoff counter and event counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  active-low enable; when high, no sample is accepted and all state is held.
- din  input  FEAT_WIDTH  signed NE feature value.
- din_valid  input  1  feature strobe from the NE datapath data_valid.
- thr_hi  input  FEAT_WIDTH  signed onset threshold.
- thr_lo  input  FEAT_WIDTH  signed release threshold.
- n_confirm  input  CNT_WIDTH  consecutive above-threshold windows required to alarm.
- n_holdoff  input  CNT_WIDTH  accepted windows ignored after an alarm ends.
- detect  output  1  high while in ALARM.
- detect_pulse  output  1  one-cycle pulse on entry to ALARM.
- event_count  output  CNT_WIDTH  number of alarms since reset; saturating.
- peak  output  FEAT_WIDTH  maximum din during the current or most recent alarm.
- state  output  2  current FSM state: IDLE=0, PEND=1, ALARM=2, HOLD=3.

Behaviour:
- Accepted sample: din_valid=1 and en=0 on a rising clk edge. Only accepted samples advance counters or the FSM.
- All comparisons are signed, full FEAT_WIDTH. No arithmetic is done on din.
- Reset (rst=0, asynchronous, any state, including mid-alarm):
  - state=IDLE; detect=0; detect_pulse=0; event_count=0; peak=0.
  - Internal confirm and holdoff counters = 0.
- All outputs are registered. detect and detect_pulse go high the cycle after the edge that accepts the confirming sample.
- IDLE:
  - On an accepted din>thr_hi: confirm count=1.
  - If n_confirm<=1, go to ALARM; otherwise go to PEND.
- PEND:
  - On an accepted din>thr_hi: confirm count+1; when count+1>=n_confirm, go to ALARM.
  - On an accepted din<=thr_hi: confirm count=0 and go to IDLE.
  - n_confirm is sampled live each cycle. Lowering it below the current count causes ALARM on the next accepted above-threshold sample.
- Entering ALARM:
  - detect_pulse=1 for exactly one cycle.
  - event_count+1, saturating at 2^CNT_WIDTH-1.
  - peak is loaded with the triggering din.
- ALARM:
  - detect=1; peak=max(peak, din) on each accepted sample.
  - On an accepted din<thr_lo: detect=0. If n_holdoff=0, go to IDLE; otherwise load holdoff=n_holdoff and go to HOLD.
  - A sample that is both above peak and below thr_lo (only possible when thr_lo>thr_hi) updates peak first, then exits.
- HOLD:
  - detect=0; threshold comparisons are ignored.
  - Each accepted sample decrements holdoff; at 0, go to IDLE with confirm count=0.
  - The sample that ends HOLD is not evaluated against thr_hi.
- peak holds its value outside ALARM until the next ALARM entry.
- detect_pulse never asserts in two consecutive cycles. A minimum ALARM→HOLD/IDLE→ALARM cycle spans at least two accepted samples.
- en=1 or din_valid=0: all state, counters and outputs are held, except detect_pulse, which returns to 0.

Decomposition:
- Shared package ne_pkg holds:
  - FSM state encoding constants (IDLE/PEND/ALARM/HOLD).
  - Default FEAT_WIDTH (40) and CNT_WIDTH (8), shared with the NE datapath.
- One natural sub-module: ne_sat_counter, a parameterised counter with load, increment-saturating and decrement-to-zero modes and active-low async reset.
  - Instanced three times: confirm, holdoff, event_count.
- FSM and peak tracking stay in the top module.

Test Plan:
- Common setup unless stated: thr_hi=1000, thr_lo=500, n_confirm=3, n_holdoff=2, en=0.
- Confirmation: accepted din 1200,1300,1400 → detect=1 and detect_pulse=1 one cycle after the third; pulse lasts 1 cycle; event_count=1; peak=1400; state=2.
- Broken run: 1200,1300,900,1500 → no detect; state back to IDLE after 900, PEND after 1500; event_count=0.
- Release and refractory: from ALARM (peak 1400) feed 1600,400 → peak=1600, detect=0, state=HOLD. Then 2000,2000 → still detect=0, state=IDLE after the second. Then 1200×3 → second alarm, event_count=2, peak=1200.
- Gating: in PEND with count 2, hold en=1 and din_valid=1 with din=1500 for 10 cycles → no state change. Then release en and feed one 1500 → ALARM. Same result with din_valid low between samples.
- Edge configs:
  - n_confirm=0 → a single 1200 alarms.
  - n_holdoff=0 → 400 in ALARM goes straight to IDLE.
  - CNT_WIDTH=2 with 5 alarms → event_count saturates at 3.
- Async reset: assert rst=0 mid-cycle while in ALARM → outputs clear immediately without a clock edge: detect=0, event_count=0, peak=0, state=0. After release, 1200×3 produces a normal alarm with event_count=1.
